// File: rtl/spawnout_queue_reader.sv
// rtl/spawnout_queue_reader.sv - spawn-out queue consumer: polls entry headers, streams entries, clears valid bytes
module spawnout_queue_reader #(
  parameter int QUEUE_LEN  = 1024,
  parameter int QUEUE_BITS = $clog2(QUEUE_LEN)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [31:0] spawnout_queue_addr,
  output logic        spawnout_queue_en,
  output logic [7:0]  spawnout_queue_we,
  output logic [63:0] spawnout_queue_din,
  input  logic [63:0] spawnout_queue_dout,
  output logic [63:0] outStream_TDATA,
  output logic        outStream_TVALID,
  input  logic        outStream_TREADY,
  output logic        outStream_TLAST,
  output logic        busy
);

  // Header layout shared with the spawn-out writer
  localparam int ENTRY_VALID_OFFSET      = 63;
  localparam int ENTRY_VALID_BYTE_OFFSET = 7;
  localparam int NUM_ARGS_OFFSET         = 32;
  localparam int NUM_DEPS_OFFSET         = 40;
  localparam int NUM_COPS_OFFSET         = 48;
  localparam int COPY_WORDS              = 3;

  localparam logic [7:0] VALID_BYTE_WE = 8'(1 << ENTRY_VALID_BYTE_OFFSET);

  typedef enum logic [2:0] {
    IDLE,
    POLL,
    SEND,
    RD,
    CAP,
    CLR_HDR
  } state_t;

  state_t                state;
  logic [QUEUE_BITS-1:0] r_idx;
  logic [6:0]            k;
  logic [6:0]            len;
  logic [63:0]           obuf;

  logic [QUEUE_BITS-1:0] word_idx;
  logic [QUEUE_BITS-1:0] acc_idx;
  logic [6:0]            hdr_len;
  logic [3:0]            num_args;
  logic [3:0]            num_deps;
  logic [3:0]            num_cops;
  logic                  last_word;
  logic                  mem_en;
  logic [7:0]            mem_we;

  // Entry length derived from the header counts; wraps naturally in 7 bits
  assign num_args = spawnout_queue_dout[NUM_ARGS_OFFSET +: 4];
  assign num_deps = spawnout_queue_dout[NUM_DEPS_OFFSET +: 4];
  assign num_cops = spawnout_queue_dout[NUM_COPS_OFFSET +: 4];
  assign hdr_len  = 7'd4 + 7'(num_args) + 7'(num_deps) + 7'(num_cops) * 7'(COPY_WORDS);

  assign word_idx  = r_idx + QUEUE_BITS'(k);
  assign last_word = (k == len - 7'd1);

  // BRAM port decode: poll in IDLE, body read in RD, valid-byte clears in CAP and CLR_HDR
  always_comb begin
    mem_en  = 1'b0;
    mem_we  = 8'h00;
    acc_idx = r_idx;
    if (!rst) begin
      case (state)
        IDLE:    mem_en = enable;
        RD:      begin mem_en = 1'b1; acc_idx = word_idx; end
        CAP:     begin mem_en = 1'b1; mem_we = VALID_BYTE_WE; acc_idx = word_idx; end
        CLR_HDR: begin mem_en = 1'b1; mem_we = VALID_BYTE_WE; end
        default: mem_en = 1'b0;
      endcase
    end
  end

  assign spawnout_queue_en   = mem_en;
  assign spawnout_queue_we   = mem_we;
  assign spawnout_queue_din  = '0;
  assign spawnout_queue_addr = mem_en ? (32'(acc_idx) << 3) : 32'd0;

  assign outStream_TVALID = !rst && (state == SEND);
  assign outStream_TLAST  = !rst && (state == SEND) && last_word;
  assign outStream_TDATA  = rst ? 64'd0 : obuf;
  assign busy             = !rst && (state != IDLE) && (state != POLL);

  // Entry sequencing: header poll, per-word stream/fetch/clear, header release last
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r_idx <= '0;
      k     <= '0;
      len   <= '0;
      obuf  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= POLL;
        end
        POLL: begin
          if (spawnout_queue_dout[ENTRY_VALID_OFFSET]) begin
            len   <= hdr_len;
            obuf  <= spawnout_queue_dout;
            k     <= '0;
            state <= SEND;
          end else begin
            state <= IDLE;
          end
        end
        SEND: begin
          if (outStream_TREADY) begin
            if (last_word) begin
              state <= CLR_HDR;
            end else begin
              k     <= k + 7'd1;
              state <= RD;
            end
          end
        end
        RD: begin
          state <= CAP;
        end
        CAP: begin
          obuf  <= spawnout_queue_dout;
          state <= SEND;
        end
        CLR_HDR: begin
          r_idx <= r_idx + QUEUE_BITS'(len);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spawnout_queue_reader.sv
// tb/tb_spawnout_queue_reader.sv - randomized self-checking bench for spawnout_queue_reader
module tb_spawnout_queue_reader;

  localparam int QL = 1024;
  localparam logic [63:0] VMASK = 64'h00FF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        tready = 1'b1;
  logic [31:0] addr;
  logic        en;
  logic [7:0]  we;
  logic [63:0] din;
  logic [63:0] dout = 64'd0;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        busy;
  logic [9:0]  bidx;

  always #5 clk = ~clk;

  spawnout_queue_reader #(.QUEUE_LEN(QL)) dut (
    .clk(clk),
    .rst(rst),
    .enable(enable),
    .spawnout_queue_addr(addr),
    .spawnout_queue_en(en),
    .spawnout_queue_we(we),
    .spawnout_queue_din(din),
    .spawnout_queue_dout(dout),
    .outStream_TDATA(tdata),
    .outStream_TVALID(tvalid),
    .outStream_TREADY(tready),
    .outStream_TLAST(tlast),
    .busy(busy)
  );

  // Queue BRAM: 1-cycle read latency, read-first, byte write enables
  logic [63:0] mem [QL];
  assign bidx = addr[12:3];
  always @(posedge clk) begin
    if (en) begin
      dout <= mem[bidx];
      for (int b = 0; b < 8; b++)
        if (we[b]) mem[bidx][b*8 +: 8] = din[b*8 +: 8];
    end
  end

  typedef struct {
    logic [63:0] d;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  logic [63:0] ent[$];
  int          wr_log[$];
  int          ent_start = 0;
  int          exp_ridx = 0;
  int          beat_cnt = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          mode = 0;
  int          pat = 0;
  logic        chk_on = 1'b0;
  logic        stalled = 1'b0;
  logic [63:0] prev_d = 64'd0;
  logic        prev_l = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Sink ready pattern: 0 always ready, 1 the 1-0-0-1 cycle, 2 random, 3 held off
  always @(posedge clk) begin
    #1;
    case (mode)
      0: tready = 1'b1;
      1: begin tready = (pat == 0) || (pat == 3); pat = (pat + 1) % 4; end
      2: tready = 1'($urandom);
      default: tready = 1'b0;
    endcase
  end

  // Per-cycle compare of stream beats and BRAM accesses against the model
  always @(negedge clk) begin
    beat_t b;
    if (chk_on) begin
      if (en) begin
        check("addr_pad", {45'd0, addr[31:13], addr[2:0]}, 64'd0);
        if (we != 8'h00) begin
          check("we_mask", 64'(we), 64'h80);
          check("din_zero", din, 64'd0);
          wr_log.push_back(int'(bidx));
        end
      end
      if (stalled) begin
        check("tvalid_held", 64'(tvalid), 64'd1);
        check("tdata_stable", tdata, prev_d);
        check("tlast_stable", 64'(tlast), 64'(prev_l));
      end
      if (tvalid) begin
        check("no_bram_in_send", 64'(en), 64'd0);
        check("busy_in_send", 64'(busy), 64'd1);
        if (tready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL stray_beat: got beat %h, want none", tdata);
          end else begin
            b = exp_q.pop_front();
            check("tdata", tdata, b.d);
            check("tlast", 64'(tlast), 64'(b.l));
          end
          beat_cnt++;
        end
      end
      stalled = tvalid && !tready;
      prev_d  = tdata;
      prev_l  = tlast;
    end else begin
      stalled = 1'b0;
    end
  end

  // Writer behaviour: body words first, header last; the model queues the expected beats
  task automatic install();
    int n;
    n = ent.size();
    for (int i = 1; i < n; i++) mem[(ent_start + i) % QL] = ent[i];
    mem[ent_start] = ent[0];
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.d = ent[i];
      b.l = (i == n - 1);
      exp_q.push_back(b);
    end
    exp_ridx = (ent_start + n) % QL;
    beat_cnt = 0;
  endtask

  task automatic gen_entry(input int len);
    int c_lo, c_hi, c, rest, a, d;
    c_lo = (len > 34) ? (len - 34 + 2) / 3 : 0;
    c_hi = (len - 4) / 3;
    if (c_hi > 15) c_hi = 15;
    c    = $urandom_range(c_hi, c_lo);
    rest = len - 4 - 3 * c;
    a    = $urandom_range((rest > 15) ? 15 : rest, (rest > 15) ? rest - 15 : 0);
    d    = rest - a;
    ent.delete();
    ent.push_back({8'h80, 4'($urandom), 4'(c), 4'($urandom), 4'(d), 4'($urandom), 4'(a), 32'($urandom)});
    for (int i = 1; i < len; i++) ent.push_back({1'b1, 31'($urandom), 32'($urandom)});
  endtask

  task automatic verify_cleared(input string name);
    for (int i = 0; i < ent.size(); i++)
      check({name, "_cleared"}, mem[(ent_start + i) % QL], ent[i] & VMASK);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic wait_poll(input string name, input int idx);
    int n;
    n = 0;
    while (!(en && we == 8'h00) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({name, "_poll_addr"}, 64'(addr), 64'(idx * 8));
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got no finish, want finish within 90000 cycles");
    $fatal(1, "watchdog");
  end

  initial begin
    int rem, len, n, nreads;
    int wexp[6];
    wexp = '{1022, 1023, 0, 1, 2, 1021};
    for (int i = 0; i < QL; i++) mem[i] = 64'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", 64'(tvalid), 64'd0);
    check("rst_tlast", 64'(tlast), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_en", 64'(en), 64'd0);
    check("rst_tdata", tdata, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_on = 1'b1;

    // Minimal entry at index 0
    @(posedge clk); #1;
    ent.delete();
    ent.push_back(64'h8000_0000_DEAD_BEEF);
    ent.push_back(64'h11);
    ent.push_back(64'h22);
    ent.push_back(64'h5);
    ent_start = 0;
    install();
    enable = 1'b1;
    wait_drain("min");
    check("min_beats", 64'(beat_cnt), 64'd4);
    verify_cleared("min");
    check("min_hdr_lit", mem[0], 64'h0000_0000_DEAD_BEEF);
    check("min_w1_lit", mem[1], 64'h11);
    wait_poll("min", 4);

    // Full entry: args=2 deps=1 cops=1 -> 10 words
    @(posedge clk); #1;
    ent.delete();
    ent.push_back({32'h8001_0102, 32'($urandom)});
    for (int i = 1; i < 10; i++) ent.push_back({1'b1, 31'($urandom), 32'($urandom)});
    ent_start = 4;
    install();
    wait_drain("full");
    check("full_beats", 64'(beat_cnt), 64'd10);
    verify_cleared("full");
    wait_poll("full", 14);

    // Random entries under backpressure until the queue start reaches 1021
    rem = 1021 - exp_ridx;
    n = 0;
    while (rem > 0) begin
      len  = (rem <= 79) ? rem : $urandom_range((rem - 4 > 79) ? 79 : rem - 4, 4);
      mode = (n < 3) ? 1 : $urandom_range(2, 0);
      repeat ($urandom_range(4, 0)) @(posedge clk);
      @(posedge clk); #1;
      ent_start = exp_ridx;
      gen_entry(len);
      install();
      wait_drain("rand");
      check("rand_beats", 64'(beat_cnt), 64'(len));
      verify_cleared("rand");
      wait_poll("rand", exp_ridx);
      rem -= len;
      n++;
    end
    mode = 0;

    // Wrap-around entry at 1021, len 6
    @(posedge clk); #1;
    ent.delete();
    ent.push_back({32'h8000_0002, 32'($urandom)});
    for (int i = 1; i < 6; i++) ent.push_back({1'b1, 31'($urandom), 32'($urandom)});
    ent_start = 1021;
    wr_log.delete();
    install();
    wait_drain("wrap");
    check("wrap_beats", 64'(beat_cnt), 64'd6);
    check("wrap_nwrites", 64'(wr_log.size()), 64'd6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++)
      check("wrap_wr_idx", 64'(wr_log[i]), 64'(wexp[i]));
    verify_cleared("wrap");
    wait_poll("wrap", 3);

    // Empty queue polling, then enable low, then a late valid header
    nreads = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("empty_no_tvalid", 64'(tvalid), 64'd0);
      if (en && we == 8'h00) begin
        nreads++;
        check("empty_poll_addr", 64'(addr), 64'd24);
      end
    end
    check("empty_poll_rate", 64'(nreads >= 9 && nreads <= 11), 64'd1);
    @(posedge clk); #1;
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("disabled_en", 64'(en), 64'd0);
    end
    @(posedge clk); #1;
    ent_start = 3;
    gen_entry(4);
    install();
    @(posedge clk); #1;
    enable = 1'b1;
    n = 0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (tvalid) break;
    end
    check("poll_latency", 64'(n), 64'd3);
    wait_drain("late");
    verify_cleared("late");
    wait_poll("late", 7);

    // Reset while word 5 of a 10-word entry is pending
    @(posedge clk); #1;
    ent_start = 7;
    gen_entry(10);
    install();
    n = 0;
    while (beat_cnt < 4 && n < 200) begin
      @(negedge clk);
      n++;
    end
    mode = 3;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(tvalid && beat_cnt == 4) && n < 50);
    check("word5_pending", 64'(tvalid && beat_cnt == 4), 64'd1);
    @(posedge clk); #1;
    chk_on = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_tvalid", 64'(tvalid), 64'd0);
    check("mid_rst_tlast", 64'(tlast), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_en", 64'(en), 64'd0);
    check("mid_rst_we", 64'(we), 64'd0);
    check("mid_rst_addr", 64'(addr), 64'd0);
    check("mid_rst_din", din, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    mode = 0;
    exp_q.delete();
    chk_on = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    wait_poll("post_rst", 0);
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
